// File: rtl/pwm_capture.sv
`default_nettype none
// =============================================================================
// Module      : pwm_capture
// Description : Measures the high time and rise-to-rise period of an
//               asynchronous PWM input, with timeout on missing edges.
//               Optional glitch filter: define PWM_CAPTURE_FILTER_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module pwm_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             pwm_clk,
    input  logic             pwm_reset,
    input  logic             cap_en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] cap_high,
    output logic [CNT_W-1:0] cap_period,
    output logic             cap_valid,
    output logic             cap_timeout
);

    // The counter value at which the cycle that would reach TIMEOUT fires instead
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] cap_high_q, cap_high_d;
    logic [CNT_W-1:0] cap_period_q, cap_period_d;
    logic             cap_valid_q, cap_valid_d;
    logic             cap_timeout_q, cap_timeout_d;

    logic sync1_q, sync2_q, prev_q;
    logic w_level, w_rise, w_fall, w_tmo;
    logic [CNT_W-1:0] w_cnt_inc;

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    always_ff @(posedge pwm_clk) begin
        if (pwm_reset) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
            if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1]))
                filt_q <= sync2_q;
        end
    end

    assign w_level = filt_q;
`else
    assign w_level = sync2_q;
`endif

    always_ff @(posedge pwm_clk) begin
        if (pwm_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= w_level;
        end
    end

    assign w_rise    = w_level & ~prev_q;
    assign w_fall    = ~w_level & prev_q;
    assign w_tmo     = (cnt_q == c_tmo_last);
    assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + c_one;

    always_comb begin
        state_d       = state_q;
        cnt_d         = w_cnt_inc;
        high_d        = high_q;
        cap_high_d    = cap_high_q;
        cap_period_d  = cap_period_q;
        cap_valid_d   = 1'b0;
        cap_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cap_en)
                    state_d = S_ARM;
            end
            S_ARM: begin
                if (w_rise) begin
                    state_d = S_HIGH;
                    cnt_d   = c_one;
                end else if (w_tmo) begin
                    cap_timeout_d = 1'b1;
                    cnt_d         = '0;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    high_d  = cnt_q;
                    state_d = S_LOW;
                end else if (w_tmo) begin
                    cap_timeout_d = 1'b1;
                    state_d       = S_ARM;
                    cnt_d         = '0;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    cap_period_d = cnt_q;
                    cap_high_d   = high_q;
                    cap_valid_d  = 1'b1;
                    cnt_d        = c_one;
                    state_d      = S_HIGH;
                end else if (w_tmo) begin
                    cap_timeout_d = 1'b1;
                    state_d       = S_ARM;
                    cnt_d         = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Disable wins over any edge or timeout seen in the same cycle
        if (!cap_en) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            high_d        = high_q;
            cap_high_d    = cap_high_q;
            cap_period_d  = cap_period_q;
            cap_valid_d   = 1'b0;
            cap_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge pwm_clk) begin
        if (pwm_reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            high_q        <= '0;
            cap_high_q    <= '0;
            cap_period_q  <= '0;
            cap_valid_q   <= 1'b0;
            cap_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_q        <= high_d;
            cap_high_q    <= cap_high_d;
            cap_period_q  <= cap_period_d;
            cap_valid_q   <= cap_valid_d;
            cap_timeout_q <= cap_timeout_d;
        end
    end

    assign cap_high    = cap_high_q;
    assign cap_period  = cap_period_q;
    assign cap_valid   = cap_valid_q;
    assign cap_timeout = cap_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// =============================================================================
// Module      : tb_pwm_capture
// Description : Directed self-checking bench for pwm_capture (TIMEOUT=1000).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_pwm_capture;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMO   = 1000;
    // Iterations from driving pwm_in to seeing the registered result
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    logic             pwm_clk = 1'b0;
    logic             pwm_reset;
    logic             cap_en;
    logic             pwm_in;
    logic [CNT_W-1:0] cap_high;
    logic [CNT_W-1:0] cap_period;
    logic             cap_valid;
    logic             cap_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) u_dut (
        .pwm_clk     (pwm_clk),
        .pwm_reset   (pwm_reset),
        .cap_en      (cap_en),
        .pwm_in      (pwm_in),
        .cap_high    (cap_high),
        .cap_period  (cap_period),
        .cap_valid   (cap_valid),
        .cap_timeout (cap_timeout)
    );

    always #5 pwm_clk = ~pwm_clk;

    task automatic tick();
        @(posedge pwm_clk);
        #1;
    endtask

    task automatic prep();
        cap_en = 1'b0;
        pwm_in = 1'b0;
        repeat (12) tick();
        cap_en = 1'b1;
    endtask

    task automatic test_reset();
        pwm_reset = 1'b1;
        cap_en    = 1'b1;
        pwm_in    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pwm_in = i[0];
            tick();
        end
        n_checks++;
        if (cap_high !== 16'd0 || cap_period !== 16'd0 || cap_valid !== 1'b0 || cap_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: high=%0d period=%0d valid=%0b timeout=%0b, expected all 0",
                     cap_high, cap_period, cap_valid, cap_timeout);
        end
        pwm_reset = 1'b0;
        cap_en    = 1'b0;
        pwm_in    = 1'b0;
        tick();
        n_checks++;
        if (cap_valid !== 1'b0 || cap_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%0b timeout=%0b, expected 0/0", cap_valid, cap_timeout);
        end
    endtask

    // Periodic PWM starting at k=0; valid expected from the second rise on
    task automatic test_pattern(input string name, input int per, input int hi, input int nper);
        int k, m, nv;
        logic ev;
        prep();
        nv = 0;
        for (int i = 0; i < 10 + nper * per + LAT + 2; i++) begin
            k = i - 10;
            pwm_in = (k >= 0) && (k < nper * per) && ((k % per) < hi);
            tick();
            m  = k - LAT;
            ev = (m >= per) && (m < nper * per) && ((m % per) == 0);
            if (cap_valid === 1'b1) nv++;
            n_checks++;
            if (cap_valid !== ev || cap_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_valid k=%0d: valid=%0b timeout=%0b, expected %0b/0", name, k, cap_valid, cap_timeout, ev);
            end
            if (ev) begin
                n_checks++;
                if (cap_high !== CNT_W'(hi) || cap_period !== CNT_W'(per)) begin
                    n_fail++;
                    $display("FAIL %s_values k=%0d: high=%0d period=%0d, expected %0d/%0d", name, k, cap_high, cap_period, hi, per);
                end
            end
        end
        n_checks++;
        if (nv != nper - 1) begin
            n_fail++;
            $display("FAIL %s_count: valid pulses=%0d, expected %0d", name, nv, nper - 1);
        end
    endtask

    task automatic test_duty0(input int hold_hi, input int hold_per);
        logic et;
        prep();
        for (int i = 0; i < 2100; i++) begin
            pwm_in = 1'b0;
            tick();
            et = (i == TMO) || (i == 2 * TMO);
            n_checks++;
            if (cap_timeout !== et || cap_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL duty0 i=%0d: timeout=%0b valid=%0b, expected %0b/0", i, cap_timeout, cap_valid, et);
            end
        end
        n_checks++;
        if (cap_high !== CNT_W'(hold_hi) || cap_period !== CNT_W'(hold_per)) begin
            n_fail++;
            $display("FAIL duty0_hold: high=%0d period=%0d, expected %0d/%0d", cap_high, cap_period, hold_hi, hold_per);
        end
    endtask

    // Continues from the ARM state left by test_duty0
    task automatic test_duty100();
        int t, r;
        logic et, ev;
        t = LAT + TMO - 1;
        r = t + 40;
        for (int i = 0; i < r + 100 + LAT + 3; i++) begin
            pwm_in = (i < t + 20) || (i >= r && i < r + 30) || (i >= r + 100 && i < r + 120);
            tick();
            et = (i == t);
            ev = (i == r + 100 + LAT);
            n_checks++;
            if (cap_timeout !== et || cap_valid !== ev) begin
                n_fail++;
                $display("FAIL duty100 i=%0d: timeout=%0b valid=%0b, expected %0b/%0b", i, cap_timeout, cap_valid, et, ev);
            end
            if (ev) begin
                n_checks++;
                if (cap_high !== 16'd30 || cap_period !== 16'd100) begin
                    n_fail++;
                    $display("FAIL duty100_rearm: high=%0d period=%0d, expected 30/100", cap_high, cap_period);
                end
            end
        end
    endtask

    task automatic test_disable(input int hold_hi, input int hold_per);
        int k;
        logic ev;
        prep();
        for (int i = 0; i < 10 + 768 + LAT + 3; i++) begin
            k = i - 10;
            cap_en = !((k >= 150) && (k < 300));
            pwm_in = (k >= 0) && ((k % 256) < 64);
            tick();
            ev = (k == 768 + LAT);
            n_checks++;
            if (cap_valid !== ev || cap_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL disable_valid k=%0d: valid=%0b timeout=%0b, expected %0b/0", k, cap_valid, cap_timeout, ev);
            end
            if (k == 299) begin
                n_checks++;
                if (cap_high !== CNT_W'(hold_hi) || cap_period !== CNT_W'(hold_per)) begin
                    n_fail++;
                    $display("FAIL disable_hold: high=%0d period=%0d, expected %0d/%0d", cap_high, cap_period, hold_hi, hold_per);
                end
            end
            if (ev) begin
                n_checks++;
                if (cap_high !== 16'd64 || cap_period !== 16'd256) begin
                    n_fail++;
                    $display("FAIL disable_values: high=%0d period=%0d, expected 64/256", cap_high, cap_period);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        logic ev;
        prep();
        for (int i = 0; i < 10 + 356 + LAT + 3; i++) begin
            k = i - 10;
            pwm_reset = (k == 20);
            pwm_in = (k >= 0 && k < 20) || (k >= 100 && k < 164) || (k >= 356 && k < 420);
            tick();
            if (k == 20) begin
                n_checks++;
                if (cap_high !== 16'd0 || cap_period !== 16'd0 || cap_valid !== 1'b0 || cap_timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_outputs: high=%0d period=%0d valid=%0b timeout=%0b, expected all 0",
                             cap_high, cap_period, cap_valid, cap_timeout);
                end
            end
            ev = (k == 356 + LAT);
            n_checks++;
            if (cap_valid !== ev || cap_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_valid k=%0d: valid=%0b timeout=%0b, expected %0b/0", k, cap_valid, cap_timeout, ev);
            end
            if (ev) begin
                n_checks++;
                if (cap_high !== 16'd64 || cap_period !== 16'd256) begin
                    n_fail++;
                    $display("FAIL reset_mid_values: high=%0d period=%0d, expected 64/256", cap_high, cap_period);
                end
            end
        end
        pwm_reset = 1'b0;
    endtask

    // One-cycle glitch in ARM: seen as an edge only when the filter is absent
    task automatic test_glitch();
        int k, eh, ep;
        logic ev;
        prep();
        for (int i = 0; i < 10 + 306 + LAT + 3; i++) begin
            k = i - 10;
            pwm_in = (k == 0) || (k >= 50 && k < 114) || (k >= 306 && k < 370);
            tick();
`ifdef PWM_CAPTURE_FILTER_EN
            ev = (k == 306 + LAT);
            eh = 64;
            ep = 256;
`else
            ev = (k == 50 + LAT) || (k == 306 + LAT);
            eh = (k == 50 + LAT) ? 1 : 64;
            ep = (k == 50 + LAT) ? 50 : 256;
`endif
            n_checks++;
            if (cap_valid !== ev || cap_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_valid k=%0d: valid=%0b timeout=%0b, expected %0b/0", k, cap_valid, cap_timeout, ev);
            end
            if (ev) begin
                n_checks++;
                if (cap_high !== CNT_W'(eh) || cap_period !== CNT_W'(ep)) begin
                    n_fail++;
                    $display("FAIL glitch_values k=%0d: high=%0d period=%0d, expected %0d/%0d", k, cap_high, cap_period, eh, ep);
                end
            end
        end
    endtask

    initial begin
        pwm_reset = 1'b1;
        cap_en    = 1'b0;
        pwm_in    = 1'b0;
        test_reset();
        test_pattern("steady", 256, 64, 4);
        test_pattern("back_to_back_a", 100, 30, 3);
        test_pattern("back_to_back_b", 20, 3, 3);
        test_duty0(3, 20);
        test_duty100();
        test_disable(30, 100);
        test_reset_mid();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
